serial_adder_seq: RTL and testbench

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

---
 rtl/serial_adder_seq_pkg.sv | 10 +
 rtl/serial_adder_seq_adder4.sv | 36 +++
 rtl/serial_adder_seq.sv | 113 +++++++++++
 tb/tb_serial_adder_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_adder_seq_pkg;
  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;
endpackage

// File: rtl/serial_adder_seq_adder4.sv
// 4-bit carry-lookahead adder: PG generation followed by a flat carry network.
module Adder4
  import serial_adder_seq_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              c_in,
  output logic [NIBBLE-1:0] sum,
  output logic              c_out
);
  logic [NIBBLE-1:0] p;
  logic [NIBBLE-1:0] g;
  logic [NIBBLE:0]   c;

  always_comb begin : pg_gen
    p = a ^ b;
    g = a & b;
  end

  always_comb begin : carry_gen
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
  end

  assign sum   = p ^ c[NIBBLE-1:0];
  assign c_out = c[NIBBLE];
endmodule

// File: rtl/serial_adder_seq.sv
// Nibble-serial adder: one 4-bit CLA slice per cycle, LSB nibble first,
// with a valid/ready operand bundle in and result bundle out.
module serial_adder_seq
  import serial_adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_cIn,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_s,
  output logic             io_cOut,
  output logic             io_ovf
);
  localparam int NIBS = WIDTH / NIBBLE;
  localparam int CW   = $clog2(NIBS);
  localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE-1:0] nib_a;
  logic [NIBBLE-1:0] nib_b;
  logic [NIBBLE-1:0] nib_s;
  logic              nib_c;

  assign nib_a = a_q[cnt_q*NIBBLE +: NIBBLE];
  assign nib_b = b_q[cnt_q*NIBBLE +: NIBBLE];

  Adder4 u_adder4 (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .sum   (nib_s),
    .c_out (nib_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          a_d     = io_a;
          b_d     = io_b;
          carry_d = io_cIn;
          cnt_d   = '0;
          s_d     = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[cnt_q*NIBBLE +: NIBBLE] = nib_s;
        carry_d = nib_c;
        if (cnt_q == LAST) begin
          // Top nibble's MSB is the result sign bit.
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1])
                & (nib_s[NIBBLE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io_in_ready  = (state_q == IDLE);
  assign io_out_valid = (state_q == DONE);
  assign io_s         = s_q;
  assign io_cOut      = carry_q;
  assign io_ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and randomized self-checking bench for serial_adder_seq.
module tb_serial_adder_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_a;
  logic [15:0] io_b;
  logic        io_cIn;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_s;
  logic        io_cOut;
  logic        io_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder_seq #(.WIDTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_cIn       (io_cIn),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_s         (io_s),
    .io_cOut      (io_cOut),
    .io_ovf       (io_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clock);
    io_in_valid = 1'b0;
    io_a  = $urandom();
    io_b  = $urandom();
    io_cIn = $urandom_range(0, 1);
    while (!io_out_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic cin,
                       input logic [15:0] es,
                       input logic ec,
                       input logic eo,
                       input int hold);
    int lat;
    @(negedge clock);
    io_a = a;
    io_b = b;
    io_cIn = cin;
    io_in_valid = 1'b1;
    io_out_ready = 1'b0;
    chk({tag, "_in_rdy"}, 32'(io_in_ready), 32'd1);
    @(posedge clock);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_s"}, 32'(io_s), 32'(es));
    chk({tag, "_cout"}, 32'(io_cOut), 32'(ec));
    chk({tag, "_ovf"}, 32'(io_ovf), 32'(eo));
    repeat (hold) begin
      @(negedge clock);
      chk({tag, "_hold"},
          32'({io_s, io_cOut, io_ovf, io_in_ready, io_out_valid}),
          32'({es, ec, eo, 1'b0, 1'b1}));
    end
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_out_ready = 1'b0;
    chk({tag, "_idle"},
        32'({io_in_ready, io_out_valid}), 32'b10);
  endtask

  initial begin
    int lat;
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic rc, ro;
    reset = 1'b0;
    io_in_valid = 1'b0;
    io_out_ready = 1'b0;
    io_a = 16'hDEAD;
    io_b = 16'hBEEF;
    io_cIn = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_flags", 32'({io_in_ready, io_out_valid}), 32'b10);
    chk("rst_res",
        32'({io_s, io_cOut, io_ovf}), 32'd0);
    reset = 1'b1;

    do_op("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("bp_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3);
    do_op("1234", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1);
    do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    do_op("m1m1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);

    // Operand bundle held valid and changing through RUN/DONE.
    @(negedge clock);
    io_a = 16'h1111;
    io_b = 16'h2222;
    io_cIn = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    while (!io_out_valid && lat < 20) begin
      io_a = $urandom();
      io_b = $urandom();
      io_cIn = $urandom_range(0, 1);
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk("ovl_lat", 32'(lat), 32'd5);
    chk("ovl_s", 32'(io_s), 32'h3333);
    chk("ovl_in_rdy", 32'(io_in_ready), 32'd0);
    io_a = 16'h0001;
    io_b = 16'h0002;
    io_cIn = 1'b1;
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_out_ready = 1'b0;
    chk("ovl_idle",
        32'({io_in_ready, io_out_valid}), 32'b10);
    @(posedge clock);
    wait_done(lat);
    chk("ovl2_lat", 32'(lat), 32'd5);
    chk("ovl2_s", 32'(io_s), 32'h0004);
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_out_ready = 1'b0;

    // Reset while RUN is on nibble 2.
    io_a = 16'h1111;
    io_b = 16'h2222;
    io_cIn = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rrun_flags",
        32'({io_in_ready, io_out_valid}), 32'b10);
    chk("rrun_res",
        32'({io_s, io_cOut, io_ovf}), 32'd0);
    reset = 1'b1;
    do_op("post_rst", 16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);

    for (int i = 0; i < 3000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = $urandom_range(0, 1);
      r = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      ro = (ra[15] == rb[15]) && (r[15] != ra[15]);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_op("rnd", ra, rb, rc, r[15:0], r[16], ro,
            $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
